saph_stream_unpack: RTL and testbench
=====================================

SAPH_STREAM_UNPACK -- requirements
Module: saph_stream_unpack

Interface
REQ-001 SHALL have parameter pack_width, default 32, meaning the input word width in bits (8+).
REQ-002 SHALL have parameter unpack_width, default 8, meaning the output number width in bits, with 2 <= unpack_width <= pack_width.
REQ-003 SHALL derive localparam unpack_exp = $clog2(unpack_width+1), used for the field width encoding.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data holds a valid packed word.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, pack_width bits: a packed word, consumed LSB-first.
REQ-009 SHALL have port cfg_width, input, unpack_exp bits: the bit width of the next field (0..unpack_width).
REQ-010 SHALL have port cfg_mode, input, 2 bits: 0 zero-extend, 1 sign-extend, 2 bit-replicate scale, 3 treated as 0.
REQ-011 SHALL have port flush, input, 1 bit: discard all buffered bits.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data holds an unpacked field.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-014 SHALL have port out_data, output, unpack_width bits: the unpacked number.
REQ-015 SHALL have port level, output, $clog2(2*pack_width+1) bits: the count of buffered, unconsumed bits.

Function
REQ-016 SHALL hold a 2*pack_width-bit bit buffer; the oldest unconsumed bit is at buffer bit 0.
REQ-017 SHALL drive in_ready = !rst && !flush && (level <= pack_width), combinationally.
REQ-018 SHALL append an accepted word (in_valid && in_ready) at buffer bit position level-after-extraction, incrementing level by pack_width.
REQ-019 SHALL define the effective width w = min(cfg_width, unpack_width).
REQ-020 SHALL perform an extraction in a cycle when level >= w and (!out_valid || out_ready) and !flush.
REQ-021 SHALL use only bits buffered at the start of the cycle for an extraction; no bypass from in_data.
REQ-022 SHALL, on extraction, register out_data from buffer bits [w-1:0], shift the buffer right by w, decrement level by w, and set out_valid the next cycle (latency 1).
REQ-023 SHALL, in the same cycle, apply both an extraction and an accept: level_next = level - w + pack_width.
REQ-024 SHALL, in mode 0, zero-fill out_data bits above w-1.
REQ-025 SHALL, in mode 1, fill out_data bits above w-1 with field bit w-1.
REQ-026 SHALL, in mode 2, place the field at out_data MSB and repeat it downward (MSB-first) to fill all unpack_width bits.
REQ-027 SHALL, for w = 0, emit out_data = 0 in every mode and consume no bits.
REQ-028 SHALL keep out_data stable and out_valid high while out_valid && !out_ready.
REQ-029 SHALL clear out_valid after a handshake when no new extraction occurs in that cycle.
REQ-030 SHALL sustain one field per cycle while out_ready is high and sufficient bits are buffered.
REQ-031 SHALL, on flush, set level to 0 and clear the buffer next cycle, leave out_valid/out_data unchanged, and perform no accept or extraction that cycle.
REQ-032 SHALL sample cfg_width/cfg_mode only in the extraction cycle; changes while stalled have no effect on already-registered out_data.

Reset
REQ-033 SHALL, while rst is high at a clock edge, set out_valid = 0, out_data = 0, level = 0, buffer = 0; in_ready reads 0 during rst.
REQ-034 SHALL, on reset mid-operation, discard buffered bits and any pending out_data, with no output handshake completing in that cycle.

Verification (pack_width=8, unpack_width=8)
REQ-035 SHALL cover: push 8'hB4, then w=3 mode 0 twice, out_ready=1 -> out_data 8'h04 then 8'h06; level 2.
REQ-036 SHALL cover: continuing from REQ-035, push 8'h03, then w=4 mode 0 -> out_data 8'h0E (field crosses words); level 6.
REQ-037 SHALL cover: push 8'h04, w=3 mode 1 -> 8'hFC; push 8'h04, w=3 mode 2 -> 8'h92; push 8'h0B, w=4 mode 2 -> 8'hBB.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles with out_valid high -> out_data constant, level unchanged, in_ready low once level > 8.
REQ-039 SHALL cover: level=5, assert flush -> level 0 next cycle, in_ready low in the flush cycle; w=0 request -> out_data 0, level stays 0.
REQ-040 SHALL cover: rst asserted with out_valid=1 and level=12 -> next cycle out_valid 0, level 0, out_data 0.

Source files
------------

// File: rtl/saph_stream_unpack.sv
// Variable-width field unpacker: packed words in, LSB-first fields out.
// Each field can be zero-extended, sign-extended or bit-replicated to full scale.
module saph_stream_unpack #(
    parameter int unsigned pack_width   = 32,
    parameter int unsigned unpack_width = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [pack_width-1:0]                  in_data,
    input  logic [$clog2(unpack_width+1)-1:0]      cfg_width,
    input  logic [1:0]                             cfg_mode,
    input  logic                                   flush,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [unpack_width-1:0]                out_data,
    output logic [$clog2(2*pack_width+1)-1:0]      level
);

    localparam int unsigned unpack_exp  = $clog2(unpack_width + 1);
    localparam int unsigned buf_width   = 2 * pack_width;
    localparam int unsigned level_width = $clog2(2 * pack_width + 1);
    localparam int unsigned idx_width   = $clog2(unpack_width);

    logic [buf_width-1:0]    bits_q;
    logic [buf_width-1:0]    bits_shift;
    logic [buf_width-1:0]    bits_next;
    logic [level_width-1:0]  level_q;
    logic [level_width-1:0]  base_level;
    logic [level_width-1:0]  level_next;
    logic [unpack_exp-1:0]   w;
    logic                    extract;
    logic                    accept;
    logic [unpack_width-1:0] raw;
    logic [unpack_width-1:0] field;
    logic [unpack_width-1:0] shaped;
    logic [idx_width-1:0]    top;
    logic [idx_width-1:0]    j;
    int                      wi;

    assign level = level_q;

    // Effective field width, clamped to the output width
    assign w = (cfg_width > unpack_exp'(unpack_width)) ? unpack_exp'(unpack_width) : cfg_width;

    assign in_ready = !rst && !flush && (level_q <= level_width'(pack_width));
    assign accept   = in_valid && in_ready;
    assign extract  = !flush && (level_q >= level_width'(w)) && (!out_valid || out_ready);
    assign raw      = bits_q[unpack_width-1:0];

    // Field masking and output shaping
    always_comb begin
        wi     = int'(w);
        top    = idx_width'(wi - 1);
        j      = top;
        field  = '0;
        shaped = '0;
        for (int i = 0; i < int'(unpack_width); i++) begin
            field[i] = (i < wi) ? raw[i] : 1'b0;
        end
        case (cfg_mode)
            2'd1: begin
                shaped = field;
                if (wi != 0) begin
                    for (int i = 0; i < int'(unpack_width); i++) begin
                        shaped[i] = (i < wi) ? field[i] : field[top];
                    end
                end
            end
            2'd2: begin
                // Walk the field MSB-first, wrapping back to its top bit
                if (wi != 0) begin
                    for (int i = int'(unpack_width) - 1; i >= 0; i--) begin
                        shaped[i] = field[j];
                        j = (j == '0) ? top : j - idx_width'(1);
                    end
                end
            end
            default: shaped = field;
        endcase
    end

    // Buffer update: consume first, then append the new word above what remains
    always_comb begin
        bits_shift = extract ? (bits_q >> w) : bits_q;
        base_level = extract ? (level_q - level_width'(w)) : level_q;
        bits_next  = bits_shift;
        level_next = base_level;
        if (accept) begin
            bits_next  = bits_shift | (buf_width'(in_data) << base_level);
            level_next = base_level + level_width'(pack_width);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q    <= '0;
            level_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (flush) begin
                bits_q  <= '0;
                level_q <= '0;
            end else begin
                bits_q  <= bits_next;
                level_q <= level_next;
            end
            if (extract) begin
                out_valid <= 1'b1;
                out_data  <= shaped;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_saph_stream_unpack.sv
// Scoreboard bench for saph_stream_unpack (pack_width=8, unpack_width=8):
// a bit-queue reference model predicts fields; a monitor checks each output handshake.
module tb_saph_stream_unpack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] cfg_width = '0;
    logic [1:0] cfg_mode = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    bit         mq[$];
    logic [7:0] expq[$];
    bit         mov = 1'b0;
    bit         started = 1'b0;

    saph_stream_unpack #(.pack_width(8), .unpack_width(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_width (cfg_width),
        .cfg_mode  (cfg_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference shaping from the field-format rules
    function automatic logic [7:0] shape(input logic [7:0] f, input int w, input int m);
        logic [7:0] v;
        v = '0;
        if (w == 0) return v;
        case (m)
            1: begin
                v = f;
                if (f[w-1]) v = f | 8'(8'hFF << w);
            end
            2: for (int i = 0; i < 8; i++) v[7-i] = f[w - 1 - (i % w)];
            default: v = f;
        endcase
        return v;
    endfunction

    // One clock cycle: check state, drive inputs, advance the model
    task automatic cycle(input bit r, input bit iv, input logic [7:0] d, input int cw,
                         input int cm, input bit fl, input bit ordy);
        bit exp_ready;
        bit ext;
        bit acc;
        int w;
        logic [7:0] f;
        @(negedge clk);
        if (started) begin
            chk("level", 32'(level), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mov));
        end
        rst = r; in_valid = iv; in_data = d; cfg_width = 4'(cw);
        cfg_mode = 2'(cm); flush = fl; out_ready = ordy;
        #1;
        exp_ready = !r && !fl && (mq.size() <= 8);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (r) begin
            mq.delete();
            expq.delete();
            mov = 1'b0;
            started = 1'b1;
        end else begin
            w   = (cw > 8) ? 8 : cw;
            ext = !fl && (mq.size() >= w) && (!mov || ordy);
            acc = iv && exp_ready;
            if (ext) begin
                f = '0;
                for (int k = 0; k < w; k++) f[k] = mq.pop_front();
                expq.push_back(shape(f, w, cm));
                mov = 1'b1;
            end else if (ordy) begin
                mov = 1'b0;
            end
            if (fl) mq.delete();
            else if (acc) for (int k = 0; k < 8; k++) mq.push_back(d[k]);
        end
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake must match the oldest prediction
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (expq.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                else chk("out_data", 32'(out_data), 32'(expq.pop_front()));
            end
        end
    end

    initial begin
        cycle(1, 0, 8'h00, 8, 0, 0, 0);
        cycle(1, 0, 8'h00, 8, 0, 0, 0);
        peek();
        chk("rst_level", 32'(level), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);

        // Fields of 3 bits from 0xB4, then one crossing into the next word
        cycle(0, 1, 8'hB4, 3, 0, 0, 1);
        cycle(0, 0, 8'h00, 3, 0, 0, 1); peek();
        chk("b4_f0", 32'(out_data), 32'h04);
        cycle(0, 0, 8'h00, 3, 0, 0, 1); peek();
        chk("b4_f1", 32'(out_data), 32'h06);
        chk("b4_level", 32'(level), 2);
        cycle(0, 1, 8'h03, 4, 0, 0, 1);
        cycle(0, 0, 8'h00, 4, 0, 0, 1); peek();
        chk("cross_f", 32'(out_data), 32'h0E);
        chk("cross_level", 32'(level), 6);
        cycle(0, 0, 8'h00, 8, 0, 1, 1);

        // Sign extend and bit replication
        cycle(0, 1, 8'h04, 3, 1, 0, 1);
        cycle(0, 0, 8'h00, 3, 1, 0, 1); peek();
        chk("mode1", 32'(out_data), 32'hFC);
        cycle(0, 0, 8'h00, 8, 0, 1, 1);
        cycle(0, 1, 8'h04, 3, 2, 0, 1);
        cycle(0, 0, 8'h00, 3, 2, 0, 1); peek();
        chk("mode2_w3", 32'(out_data), 32'h92);
        chk("level5", 32'(level), 5);
        // Flush with 5 bits buffered, then a zero-width request
        cycle(0, 1, 8'hFF, 8, 0, 1, 1); peek();
        chk("flush_level", 32'(level), 0);
        cycle(0, 0, 8'h00, 0, 2, 0, 1); peek();
        chk("w0_data", 32'(out_data), 0);
        chk("w0_level", 32'(level), 0);
        cycle(0, 1, 8'h0B, 8, 2, 0, 1);
        cycle(0, 0, 8'h00, 4, 2, 0, 1); peek();
        chk("mode2_w4", 32'(out_data), 32'hBB);
        cycle(0, 0, 8'h00, 8, 0, 1, 1);

        // Stall with output pending: data frozen, level frozen, input blocked
        cycle(0, 1, 8'hAA, 4, 0, 0, 0);
        cycle(0, 1, 8'h55, 4, 0, 0, 0); peek();
        chk("stall_data0", 32'(out_data), 32'h0A);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 8'($urandom), $urandom_range(0, 9), $urandom_range(0, 3), 0, 0);
            peek();
            chk("stall_data", 32'(out_data), 32'h0A);
            chk("stall_level", 32'(level), 12);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        // Reset mid-operation discards the pending field
        cycle(1, 0, 8'h00, 4, 0, 0, 1); peek();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_level", 32'(level), 0);
        chk("midrst_data", 32'(out_data), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0), $urandom_range(0, 1), 8'($urandom),
                  $urandom_range(0, 9), $urandom_range(0, 3),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
        end
        cycle(0, 0, 8'h00, 8, 0, 0, 1);
        cycle(0, 0, 8'h00, 8, 0, 1, 1);
        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
